// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU:
// op codes, FSM states and the bit positions of the flags.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_NOT  = 4'h4;
   localparam logic [3:0] ALU_NEG  = 4'h5;
   localparam logic [3:0] ALU_SHL1 = 4'h6;
   localparam logic [3:0] ALU_SHR1 = 4'h7;
   localparam logic [3:0] ALU_ADI  = 4'h8;
   localparam logic [3:0] ALU_ORI  = 4'h9;
   localparam logic [3:0] ALU_LHI  = 4'hA;
   localparam logic [3:0] ALU_SLL  = 4'hB;
   localparam logic [3:0] ALU_SRL  = 4'hC;
   localparam logic [3:0] ALU_SRA  = 4'hD;
   localparam logic [3:0] ALU_MUL  = 4'hE;
   localparam logic [3:0] ALU_SLT  = 4'hF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StWb   = 2'd2
   } state_e;

   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_NEG   = 1;
   localparam int unsigned FLAG_CARRY = 2;
   localparam int unsigned FLAG_OVF   = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// o_done pulses in the cycle whose clock edge performs the final step.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   logic             r_run;
   logic [CNTW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             w_last;

   assign w_last    = r_run && (r_cnt == CNTW'(WIDTH - 1));
   assign o_done    = w_last;
   assign o_product = r_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_a   <= i_a;
         r_b   <= i_b;
         r_acc <= '0;
      end else if (r_run) begin
         // Product is kept modulo 2^WIDTH, so high partial bits fall off the shifted A.
         if (r_b[0]) begin
            r_acc <= r_acc + r_a;
         end
         r_a   <= {r_a[WIDTH-2:0], 1'b0};
         r_b   <= {1'b0, r_b[WIDTH-1:1]};
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execute-stage ALU: single-cycle ops plus an iterative multiply,
// with a single-entry registered result carrying flags and a destination tag.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned TAG_W  = 2,
   parameter int unsigned MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_func,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned MSB = WIDTH - 1;

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_c;
   logic [TAG_W-1:0] r_out_tag;
   logic [TAG_W-1:0] r_mul_tag;
   logic [3:0]       r_flags;

   logic [SHW-1:0]   w_sh;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;
   logic [3:0]       w_alu_flags;
   logic [3:0]       w_mul_flags;
   logic             w_is_mul;
   logic             w_in_ready;
   logic             w_xfer;
   logic             w_alu_load;
   logic             w_wb_load;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_prod;

   assign w_sh  = in_b[SHW-1:0];
   assign w_add = {1'b0, in_a} + {1'b0, in_b};
   // Carry out of A + ~B + 1: set means no borrow occurred.
   assign w_sub = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (in_func)
         ALU_ADD, ALU_ADI: begin
            w_res   = w_add[MSB:0];
            w_carry = w_add[WIDTH];
            w_ovf   = (in_a[MSB] == in_b[MSB]) && (w_add[MSB] != in_a[MSB]);
         end
         ALU_SUB: begin
            w_res   = w_sub[MSB:0];
            w_carry = w_sub[WIDTH];
            w_ovf   = (in_a[MSB] != in_b[MSB]) && (w_sub[MSB] != in_a[MSB]);
         end
         ALU_AND:  w_res = in_a & in_b;
         ALU_OR:   w_res = in_a | in_b;
         ALU_NOT:  w_res = ~in_a;
         ALU_NEG:  w_res = ~in_a + WIDTH'(1);
         ALU_SHL1: w_res = {in_a[MSB-1:0], 1'b0};
         ALU_SHR1: w_res = {1'b0, in_a[MSB:1]};
         ALU_ORI:  w_res = in_a | in_b;
         ALU_LHI:  w_res = in_b << (WIDTH / 2);
         ALU_SLL:  w_res = in_a << w_sh;
         ALU_SRL:  w_res = in_a >> w_sh;
         ALU_SRA:  w_res = $unsigned($signed(in_a) >>> w_sh);
         ALU_MUL:  w_res = '0;
         ALU_SLT:  w_res = {{(WIDTH - 1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         default:  w_res = '0;
      endcase
   end

   always_comb begin
      w_alu_flags             = '0;
      w_alu_flags[FLAG_ZERO]  = (w_res == '0);
      w_alu_flags[FLAG_NEG]   = w_res[MSB];
      w_alu_flags[FLAG_CARRY] = w_carry;
      w_alu_flags[FLAG_OVF]   = w_ovf;
      w_mul_flags             = '0;
      w_mul_flags[FLAG_ZERO]  = (w_mul_prod == '0);
      w_mul_flags[FLAG_NEG]   = w_mul_prod[MSB];
   end

   assign w_is_mul    = (in_func == ALU_MUL) && (MUL_EN != 0);
   assign w_in_ready  = (r_state == StIdle) && (!r_out_valid || out_ready);
   assign w_xfer      = in_valid && w_in_ready;
   assign w_alu_load  = w_xfer && !w_is_mul;
   assign w_mul_start = w_xfer && w_is_mul;
   assign w_wb_load   = (r_state == StWb) && (!r_out_valid || out_ready);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_a       (in_a),
      .i_b       (in_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_mul_start) w_state_nxt = StMul;
         StMul:   if (w_mul_done) w_state_nxt = StWb;
         StWb:    if (w_wb_load) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_c     <= '0;
         r_out_tag   <= '0;
         r_flags     <= '0;
         r_mul_tag   <= '0;
      end else begin
         // A new load takes priority over a simultaneous drain.
         if (w_alu_load) begin
            r_out_valid <= 1'b1;
            r_out_c     <= w_res;
            r_out_tag   <= in_tag;
            r_flags     <= w_alu_flags;
         end else if (w_wb_load) begin
            r_out_valid <= 1'b1;
            r_out_c     <= w_mul_prod;
            r_out_tag   <= r_mul_tag;
            r_flags     <= w_mul_flags;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_mul_start) begin
            r_mul_tag <= in_tag;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_c     = r_out_c;
   assign out_tag   = r_out_tag;
   assign out_zero  = r_flags[FLAG_ZERO];
   assign out_neg   = r_flags[FLAG_NEG];
   assign out_carry = r_flags[FLAG_CARRY];
   assign out_ovf   = r_flags[FLAG_OVF];
   assign busy      = (r_state != StIdle);

endmodule
